lstm_seq_ctrl: RTL and testbench
================================

# lstm_seq_ctrl

Sequencer that drives the `LSTM` cell across a time series.
- Accepts 8-bit input samples over a valid/ready stream and holds the 13 weight/bias registers plus initial state, all loaded through a config write port.
- Runs one `LSTM` step per sample, feeding `Hout`/`Cout` back as `PrevH`/`Ci` for the next step.
- Returns each step's hidden/cell state on an output stream.
- Sits between the sample source and the `LSTM` core instance; the core is driven by this block, not a testbench.

## Interface
- `W`, 8, datapath width.
- `CORE_LAT`, 4, cycles the core needs with `En` high before `Hout`/`Cout`/`Of` are valid. Range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: config write strobe. Ignored unless state is IDLE.
- `cfg_addr` in 4: 0..12 = Ui,Uf,Uk,Uo,Wi,Wk,Wf,Wo,Vo,Bi,Bo,Bf,Bk; 13 = H0; 14 = C0; 15 ignored.
- `cfg_data` in W: config write data.
- `in_valid` / `in_ready` in/out 1: sample handshake.
- `in_data` in W: sample value.
- `in_last` in 1: marks the last sample of the sequence.
- `out_valid` / `out_ready` out/in 1: result handshake.
- `out_h`, `out_c` out W: captured `Hout`, `Cout`.
- `out_last` out 1: result belongs to the last sample of the sequence.
- `out_of` out 1: sticky OR of core `Of` over the sequence, including the current step.
- Core side:
  - Outputs `En`, `Cip` (1 bit each).
  - Outputs `In`, `Ci`, `PrevH`, `Ui`..`Bk` (W bits each).
  - Inputs `Hout`, `Cout` (W bits), `Of` (1 bit).

## Operation
- States IDLE, RUN, EMIT.
- IDLE
  - `in_ready`=1.
  - On `in_valid`: latch `in_data`→`In`, `in_last`→last_q, clear cnt, go RUN.
  - `cfg_we` writes the addressed register. A write to H0/C0 also loads `PrevH`/`Ci` when first_q=1.
- RUN
  - `En`=1 and cnt increments each cycle.
  - When cnt==CORE_LAT-1:
    - Capture `Hout`→`out_h` and `Cout`→`out_c`.
    - Set of_q |= `Of`.
    - Load `PrevH`←`Hout` and `Ci`←`Cout`.
    - Go EMIT.
- EMIT
  - `out_valid`=1; `out_last`=last_q; `out_of`=of_q.
  - On `out_ready`:
    - If last_q: `PrevH`←H0, `Ci`←C0, of_q←0, first_q←1.
    - Otherwise: first_q←0.
    - Go IDLE.
- `Cip`=~first_q: 0 on the first step of a sequence, 1 on the steps after it.
- `In`, `PrevH`, `Ci` and the weights are held stable for all of RUN.
- `cfg_we` in RUN/EMIT is dropped silently. No queuing.
- No arithmetic in this block: values pass through unchanged, no truncation.

## Timing
- Reset values:
  - state=IDLE.
  - All weight registers, H0, C0, `In`, `PrevH`, `Ci`, `out_h`, `out_c` = 0.
  - `En`=0, `Cip`=0, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_of`=0, first_q=1.
- Accept at edge 0. `En` is high for cycles 1..CORE_LAT. `out_valid` rises at cycle CORE_LAT+1.
- Minimum period is CORE_LAT+2 cycles per sample with `out_ready` held at 1.
- `out_*` hold stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` and `out_valid` are never high together. No sample is accepted before the previous result is taken.
- `rst` mid-RUN or mid-EMIT:
  - Next cycle is IDLE with reset values.
  - The in-flight result is discarded.
  - Weights are cleared and must be reloaded.

## Structure
- Package `lstm_pkg`:
  - State enum.
  - `CFG_UI`..`CFG_BK`, `CFG_H0`, `CFG_C0` address constants.
  - `NUM_CFG`=15.
- Sub-module `lstm_wreg_file`: 15×W registers with a write port and parallel outputs to the core, plus H0/C0.
- Top module holds the FSM, counter and feedback registers.

## Test plan
The bench uses a stub core: `Hout`=`In`+`PrevH` mod 256, `Cout`=`Ci`+1, `Of`=carry of `In`+`PrevH`, with latency CORE_LAT.
- Load all registers 27 and H0=C0=27, then one sample 200 with last=1. Required result: `out_h`=227, `out_c`=28, `out_of`=0, `out_last`=1, `Cip`=0, and `out_valid` rises at cycle 5 after accept.
- Sequence 200,10,50 with H0=27, C0=0. Required results:
  - `out_h` = 227, 237, 31.
  - `out_c` = 1, 2, 3.
  - `out_of` = 0, 0, 1.
  - `Cip` = 0, 1, 1.
  - After the final result, `PrevH`=27 and `Ci`=0.
- Hold `out_ready`=0 for 6 cycles in EMIT. Outputs stay stable, `in_ready`=0, and a `cfg_we` to Ui=99 is ignored (Ui stays 27).
- Assert `rst` at RUN cycle 2 of a step. Next cycle: `En`=0, `out_valid`=0, `Ui`=0, `in_ready`=1.
- CORE_LAT=1 with back-to-back `in_valid`/`out_ready`: one result every 3 cycles and `En` high exactly 1 cycle per step.

Source files
------------

// File: rtl/lstm_seq_ctrl_pkg.sv
// rtl/lstm_seq_ctrl_pkg.sv - shared types and config address map for the LSTM sequencer
package lstm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EMIT
    } state_t;

    localparam int NUM_CFG = 15;
    localparam int NUM_W   = 13;

    localparam logic [3:0] CFG_UI = 4'd0;
    localparam logic [3:0] CFG_UF = 4'd1;
    localparam logic [3:0] CFG_UK = 4'd2;
    localparam logic [3:0] CFG_UO = 4'd3;
    localparam logic [3:0] CFG_WI = 4'd4;
    localparam logic [3:0] CFG_WK = 4'd5;
    localparam logic [3:0] CFG_WF = 4'd6;
    localparam logic [3:0] CFG_WO = 4'd7;
    localparam logic [3:0] CFG_VO = 4'd8;
    localparam logic [3:0] CFG_BI = 4'd9;
    localparam logic [3:0] CFG_BO = 4'd10;
    localparam logic [3:0] CFG_BF = 4'd11;
    localparam logic [3:0] CFG_BK = 4'd12;
    localparam logic [3:0] CFG_H0 = 4'd13;
    localparam logic [3:0] CFG_C0 = 4'd14;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// rtl/lstm_seq_ctrl_if.sv - sample input and result output streams of the sequencer
interface lstm_seq_ctrl_if #(parameter int W = 8);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_h;
    logic [W-1:0] out_c;
    logic         out_last;
    logic         out_of;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_h, out_c, out_last, out_of
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_h, out_c, out_last, out_of
    );

endinterface

// File: rtl/lstm_seq_ctrl_wreg_file.sv
// rtl/lstm_seq_ctrl_wreg_file.sv - weight/bias and initial-state register file
module lstm_wreg_file
    import lstm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [3:0]              addr,
    input  logic [W-1:0]            data,
    output logic [NUM_W-1:0][W-1:0] wts,
    output logic [W-1:0]            h0,
    output logic [W-1:0]            c0
);

    logic [NUM_CFG-1:0][W-1:0] regs;

    // Address 15 has no backing register and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (we && (addr < 4'(NUM_CFG))) begin
            regs[addr] <= data;
        end
    end

    assign wts = regs[NUM_W-1:0];
    assign h0  = regs[CFG_H0];
    assign c0  = regs[CFG_C0];

endmodule

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - steps an LSTM core over a sample stream with H/C feedback
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int W        = 8,
    parameter int CORE_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    lstm_seq_ctrl_if.slave bus,
    output logic         En,
    output logic         Cip,
    output logic [W-1:0] In,
    output logic [W-1:0] Ci,
    output logic [W-1:0] PrevH,
    output logic [W-1:0] Ui,
    output logic [W-1:0] Uf,
    output logic [W-1:0] Uk,
    output logic [W-1:0] Uo,
    output logic [W-1:0] Wi,
    output logic [W-1:0] Wk,
    output logic [W-1:0] Wf,
    output logic [W-1:0] Wo,
    output logic [W-1:0] Vo,
    output logic [W-1:0] Bi,
    output logic [W-1:0] Bo,
    output logic [W-1:0] Bf,
    output logic [W-1:0] Bk,
    input  logic [W-1:0] Hout,
    input  logic [W-1:0] Cout,
    input  logic         Of
);

    localparam logic [3:0] CNT_LAST = 4'(CORE_LAT - 1);

    state_t                  state, state_nx;
    logic [3:0]              cnt;
    logic                    last_q, first_q, of_q;
    logic [W-1:0]            in_q, prev_h_q, ci_q, out_h_q, out_c_q;
    logic [NUM_W-1:0][W-1:0] wts;
    logic [W-1:0]            h0, c0;
    logic                    accept, done, take, cfg_hit;

    assign accept  = (state == ST_IDLE) && bus.in_valid;
    assign done    = (state == ST_RUN) && (cnt == CNT_LAST);
    assign take    = (state == ST_EMIT) && bus.out_ready;
    assign cfg_hit = (state == ST_IDLE) && cfg_we;

    lstm_wreg_file #(.W(W)) u_wreg (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_hit),
        .addr (cfg_addr),
        .data (cfg_data),
        .wts  (wts),
        .h0   (h0),
        .c0   (c0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN:  if (done)   state_nx = ST_EMIT;
            ST_EMIT: if (take)   state_nx = ST_IDLE;
            default:             state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_EMIT);
        bus.out_last  = (state == ST_EMIT) && last_q;
        bus.out_of    = (state == ST_EMIT) && of_q;
        En            = (state == ST_RUN);
        Cip           = ~first_q;
    end

    // Feedback registers: H0/C0 seed PrevH/Ci only while no sequence is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            last_q   <= 1'b0;
            first_q  <= 1'b1;
            of_q     <= 1'b0;
            in_q     <= '0;
            prev_h_q <= '0;
            ci_q     <= '0;
            out_h_q  <= '0;
            out_c_q  <= '0;
        end else begin
            if (accept) begin
                in_q   <= bus.in_data;
                last_q <= bus.in_last;
                cnt    <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + 4'd1;
            end
            if (cfg_hit && first_q) begin
                if (cfg_addr == CFG_H0) prev_h_q <= cfg_data;
                if (cfg_addr == CFG_C0) ci_q     <= cfg_data;
            end
            if (done) begin
                out_h_q  <= Hout;
                out_c_q  <= Cout;
                of_q     <= of_q | Of;
                prev_h_q <= Hout;
                ci_q     <= Cout;
            end
            if (take) begin
                if (last_q) begin
                    prev_h_q <= h0;
                    ci_q     <= c0;
                    of_q     <= 1'b0;
                    first_q  <= 1'b1;
                end else begin
                    first_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.out_h = out_h_q;
    assign bus.out_c = out_c_q;
    assign In        = in_q;
    assign PrevH     = prev_h_q;
    assign Ci        = ci_q;

    assign Ui = wts[CFG_UI];
    assign Uf = wts[CFG_UF];
    assign Uk = wts[CFG_UK];
    assign Uo = wts[CFG_UO];
    assign Wi = wts[CFG_WI];
    assign Wk = wts[CFG_WK];
    assign Wf = wts[CFG_WF];
    assign Wo = wts[CFG_WO];
    assign Vo = wts[CFG_VO];
    assign Bi = wts[CFG_BI];
    assign Bo = wts[CFG_BO];
    assign Bf = wts[CFG_BF];
    assign Bk = wts[CFG_BK];

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - bench for lstm_seq_ctrl with a stub adder core
module tb_lstm_seq_ctrl;
    import lstm_pkg::*;

    localparam int CL1 = 4;
    localparam int CL2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       cfg_we2 = 1'b0;
    logic [3:0] cfg_addr2 = '0;
    logic [7:0] cfg_data2 = '0;

    lstm_seq_ctrl_if #(.W(8)) bus1();
    lstm_seq_ctrl_if #(.W(8)) bus2();

    logic       en1, cip1, of1, en2, cip2, of2;
    logic [7:0] in1, ci1, prevh1, hout1, cout1;
    logic [7:0] in2, ci2, prevh2, hout2, cout2;
    logic [7:0] w1 [13];
    logic [7:0] w2 [13];
    logic [3:0] sc1, sc2;

    // Stub core: results only valid on the CL-th enabled cycle, junk otherwise.
    always_ff @(posedge clk) sc1 <= en1 ? sc1 + 4'd1 : 4'd0;
    always_ff @(posedge clk) sc2 <= en2 ? sc2 + 4'd1 : 4'd0;
    assign {of1, hout1} = (sc1 == 4'(CL1 - 1)) ? ({1'b0, in1} + {1'b0, prevh1}) : 9'h1EE;
    assign cout1        = (sc1 == 4'(CL1 - 1)) ? ci1 + 8'd1 : 8'hEE;
    assign {of2, hout2} = (sc2 == 4'(CL2 - 1)) ? ({1'b0, in2} + {1'b0, prevh2}) : 9'h1EE;
    assign cout2        = (sc2 == 4'(CL2 - 1)) ? ci2 + 8'd1 : 8'hEE;

    lstm_seq_ctrl #(.W(8), .CORE_LAT(CL1)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .bus(bus1), .En(en1), .Cip(cip1), .In(in1), .Ci(ci1), .PrevH(prevh1),
        .Ui(w1[0]), .Uf(w1[1]), .Uk(w1[2]), .Uo(w1[3]), .Wi(w1[4]), .Wk(w1[5]), .Wf(w1[6]),
        .Wo(w1[7]), .Vo(w1[8]), .Bi(w1[9]), .Bo(w1[10]), .Bf(w1[11]), .Bk(w1[12]),
        .Hout(hout1), .Cout(cout1), .Of(of1)
    );

    lstm_seq_ctrl #(.W(8), .CORE_LAT(CL2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
        .bus(bus2), .En(en2), .Cip(cip2), .In(in2), .Ci(ci2), .PrevH(prevh2),
        .Ui(w2[0]), .Uf(w2[1]), .Uk(w2[2]), .Uo(w2[3]), .Wi(w2[4]), .Wk(w2[5]), .Wf(w2[6]),
        .Wo(w2[7]), .Vo(w2[8]), .Bi(w2[9]), .Bo(w2[10]), .Bf(w2[11]), .Bk(w2[12]),
        .Hout(hout2), .Cout(cout2), .Of(of2)
    );

    typedef struct {
        logic [7:0] din;
        logic       last;
        logic [7:0] h;
        logic [7:0] c;
        logic       of;
        logic       cip;
    } vec_t;

    typedef struct {
        logic [7:0] h;
        logic [7:0] c;
        logic       of;
        logic       last;
        logic       cip;
    } exp_t;

    exp_t sbq[$];
    exp_t sb2[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drive(input vec_t v, input bit hold);
        int   k;
        int   en_n;
        logic cip_s;
        exp_t e;
        k = 0;
        while (!bus1.in_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk("in_ready_wait", bus1.in_ready, 1);
        bus1.in_data = v.din; bus1.in_last = v.last; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        e.h = v.h; e.c = v.c; e.of = v.of; e.last = v.last; e.cip = v.cip;
        sbq.push_back(e);
        cip_s = cip1;
        en_n  = int'(en1);
        k = 0;
        while (!bus1.out_valid && k < 64) begin
            @(posedge clk); #1; k++;
            en_n += int'(en1);
        end
        chk("out_valid_cycle", k + 1, CL1 + 1);
        chk("en_cycles", en_n, CL1);
        chk("cip", cip_s, e.cip);
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            if (hold) begin
                for (int j = 0; j < 6; j++) begin
                    if (j == 1) begin cfg_we = 1'b1; cfg_addr = CFG_UI; cfg_data = 8'd99; end
                    @(posedge clk); #1;
                    cfg_we = 1'b0;
                    chk("hold_h", bus1.out_h, e.h);
                    chk("hold_c", bus1.out_c, e.c);
                    chk("hold_valid", bus1.out_valid, 1);
                    chk("hold_in_ready", bus1.in_ready, 0);
                end
                chk("ui_kept", w1[0], 27);
            end
            chk("out_h", bus1.out_h, e.h);
            chk("out_c", bus1.out_c, e.c);
            chk("out_of", bus1.out_of, e.of);
            chk("out_last", bus1.out_last, e.last);
            chk("excl_emit", bus1.in_ready, 0);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    vec_t vt[4];

    initial begin
        int   n2;
        int   hs_last;
        int   nres;
        int   run;
        logic [7:0] hm;
        exp_t e2;

        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;

        vt[0] = '{din: 8'd200, last: 1'b1, h: 8'd227, c: 8'd28, of: 1'b0, cip: 1'b0};
        vt[1] = '{din: 8'd200, last: 1'b0, h: 8'd227, c: 8'd1,  of: 1'b0, cip: 1'b0};
        vt[2] = '{din: 8'd10,  last: 1'b0, h: 8'd237, c: 8'd2,  of: 1'b0, cip: 1'b1};
        vt[3] = '{din: 8'd50,  last: 1'b1, h: 8'd31,  c: 8'd3,  of: 1'b1, cip: 1'b1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", bus1.in_ready, 1);
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_en", en1, 0);
        chk("rst_cip", cip1, 0);
        chk("rst_out_last", bus1.out_last, 0);
        chk("rst_out_of", bus1.out_of, 0);
        chk("rst_out_h", bus1.out_h, 0);
        chk("rst_prevh", prevh1, 0);
        chk("rst_ui", w1[0], 0);

        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                for (int a = 0; a < 15; a++) cfg(4'(a), 8'd27);
                cfg(4'd15, 8'd55);
                for (int a = 0; a < 13; a++) chk("wreg_load", w1[a], 27);
                chk("h0_to_prevh", prevh1, 27);
                chk("c0_to_ci", ci1, 27);
            end
            if (i == 1) begin
                cfg(CFG_H0, 8'd27);
                cfg(CFG_C0, 8'd0);
                chk("seq_prevh", prevh1, 27);
                chk("seq_ci", ci1, 0);
            end
            drive(vt[i], i == 2);
        end
        chk("final_prevh", prevh1, 27);
        chk("final_ci", ci1, 0);
        chk("final_cip", cip1, 0);

        // Reset while dut1 is in its second RUN cycle.
        bus1.in_data = 8'd5; bus1.in_last = 1'b1; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_en", en1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_en", en1, 0);
        chk("midrst_out_valid", bus1.out_valid, 0);
        chk("midrst_ui", w1[0], 0);
        chk("midrst_in_ready", bus1.in_ready, 1);
        chk("midrst_prevh", prevh1, 0);

        // Back-to-back stream on the CORE_LAT=1 instance.
        n2 = 0; hs_last = -1; nres = 0; run = 0; hm = 8'd0;
        bus2.in_valid = 1'b1; bus2.out_ready = 1'b1; bus2.in_last = 1'b0;
        for (int c = 0; c < 31; c++) begin
            bus2.in_data = 8'(c * 7 + 3);
            chk("b2b_excl", bus2.in_ready & bus2.out_valid, 0);
            if (bus2.in_valid && bus2.in_ready) begin
                n2++;
                hm = hm + bus2.in_data;
                e2.h = hm; e2.c = 8'(n2); e2.of = 1'b0; e2.last = 1'b0; e2.cip = 1'b0;
                sb2.push_back(e2);
            end
            if (bus2.out_valid && bus2.out_ready) begin
                if (sb2.size() == 0) begin
                    chk("b2b_sb_empty", 1, 0);
                end else begin
                    e2 = sb2.pop_front();
                    chk("b2b_h", bus2.out_h, e2.h);
                    chk("b2b_c", bus2.out_c, e2.c);
                end
                if (hs_last >= 0) chk("b2b_period", c - hs_last, 3);
                hs_last = c;
                nres++;
            end
            if (en2) run++;
            else begin
                if (run != 0) chk("b2b_en_width", run, 1);
                run = 0;
            end
            @(posedge clk); #1;
        end
        chk("b2b_count", nres >= 9, 1);
        bus2.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
